// File: rtl/adc_sample_writer.sv
// Write-side controller for the ADC sampling FIFO: paces conversions, runs the CONVST/BUSY/CS#/RD# handshake, pushes samples.
// Optional ADC_WR_AFULL_THROTTLE_EN: skip a conversion tick while the FIFO reports almost-full.
module adc_sample_writer #(
    parameter int unsigned DIV        = 100,
    parameter int unsigned CONV_PULSE = 2,
    parameter int unsigned BUSY_TO    = 200
) (
    input  logic        wrclk,
    input  logic        reset,
    input  logic        en,
    input  logic        adc_busy,
    input  logic [15:0] adc_data,
    output logic        adc_convst,
    output logic        adc_cs_n,
    output logic        adc_rd_n,
    input  logic        fifo_full,
    input  logic        fifo_afull,
    output logic [15:0] wrdata,
    output logic        wren,
    output logic        ovf,
    output logic        tmo,
    output logic [7:0]  drop_cnt,
    input  logic        clr
);

    // state | meaning
    // IDLE  | waiting for a period tick
    // START | CONVST held low for CONV_PULSE cycles
    // WAIT  | waiting for synchronised BUSY to fall, bounded by BUSY_TO
    // READ  | CS#/RD# low for two cycles, data captured on the second
    // PUSH  | write to FIFO or account a drop
    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_START = 5'b00010;
    localparam logic [4:0] S_WAIT  = 5'b00100;
    localparam logic [4:0] S_READ  = 5'b01000;
    localparam logic [4:0] S_PUSH  = 5'b10000;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [7:0]  CP_M1  = 8'(CONV_PULSE - 1);
    localparam logic [7:0]  TO_M1  = 8'(BUSY_TO - 1);
    // Timer at or below this value means at least three cycles have been spent in WAIT.
    localparam logic [7:0]  TO_MIN = 8'(BUSY_TO - 3);

    logic [4:0]  state;
    logic [7:0]  tmr;
    logic [15:0] per_cnt;
    logic        busy_m;
    logic        busy_s;
    logic        tick;
    logic        skip;
    logic        timeout;
    logic        drop_evt;

    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= adc_busy;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
        end else if (!en) begin
            per_cnt <= '0;
        end else if (per_cnt == DIV_M1) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 16'd1;
        end
    end

    assign tick = en && (per_cnt == 16'd0);

`ifdef ADC_WR_AFULL_THROTTLE_EN
    assign skip = (state == S_IDLE) && tick && fifo_afull;
`else
    logic afull_unused;
    assign afull_unused = fifo_afull;
    assign skip = 1'b0;
`endif

    assign timeout  = (state == S_WAIT) && (tmr == 8'd0) && busy_s;
    assign drop_evt = ((state == S_PUSH) && fifo_full) || skip;

    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tmr        <= '0;
            adc_convst <= 1'b1;
            adc_cs_n   <= 1'b1;
            adc_rd_n   <= 1'b1;
            wrdata     <= '0;
            wren       <= 1'b0;
        end else begin
            wren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick && !skip) begin
                        state      <= S_START;
                        adc_convst <= 1'b0;
                        tmr        <= CP_M1;
                    end
                end
                S_START: begin
                    if (tmr == 8'd0) begin
                        state      <= S_WAIT;
                        adc_convst <= 1'b1;
                        tmr        <= TO_M1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_WAIT: begin
                    if ((tmr <= TO_MIN) && !busy_s) begin
                        state    <= S_READ;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        tmr      <= 8'd1;
                    end else if (tmr == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_READ: begin
                    if (tmr == 8'd0) begin
                        state    <= S_PUSH;
                        wrdata   <= adc_data;
                        adc_cs_n <= 1'b1;
                        adc_rd_n <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_PUSH: begin
                    wren  <= !fifo_full;
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    adc_convst <= 1'b1;
                    adc_cs_n   <= 1'b1;
                    adc_rd_n   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            tmo <= 1'b0;
        end else if (clr) begin
            tmo <= 1'b0;
        end else if (timeout) begin
            tmo <= 1'b1;
        end
    end

    // Clear takes priority over a drop landing in the same cycle.
    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_evt) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_writer.sv
// Self-checking bench for adc_sample_writer: table vectors, randomized periods against a
// per-conversion outcome model, and hand-written timeout / reset / throttle sequences.
module tb_adc_sample_writer;

    localparam int DIV = 20;
    localparam int CP  = 2;
    localparam int BTO = 50;

    logic        wrclk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        adc_busy = 1'b0;
    logic [15:0] adc_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_afull = 1'b0;
    logic        clr = 1'b0;
    logic        adc_convst, adc_cs_n, adc_rd_n, wren, ovf, tmo;
    logic [15:0] wrdata;
    logic [7:0]  drop_cnt;

    adc_sample_writer #(.DIV(DIV), .CONV_PULSE(CP), .BUSY_TO(BTO)) dut (
        .wrclk(wrclk), .reset(reset), .en(en), .adc_busy(adc_busy), .adc_data(adc_data),
        .adc_convst(adc_convst), .adc_cs_n(adc_cs_n), .adc_rd_n(adc_rd_n),
        .fifo_full(fifo_full), .fifo_afull(fifo_afull), .wrdata(wrdata), .wren(wren),
        .ovf(ovf), .tmo(tmo), .drop_cnt(drop_cnt), .clr(clr)
    );

    always #5 wrclk = ~wrclk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_drops = 0;

    // Observations from the last run_period call
    int          found, wait_cyc, wren_cnt, low_cnt, cs_cnt, skew, lat, stable_bad;
    logic [15:0] got_data;

    typedef struct {
        int          busy_len;
        logic        full;
        logic [15:0] data;
        int          exp_wren;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Waits for the next CONVST fall, plays the ADC (BUSY high busy_len cycles, data on the bus)
    // and observes the remainder of the sample period.
    task automatic run_period(input int busy_len, input logic full, input logic [15:0] data);
        logic [15:0] prev_wd;
        found = 0; wait_cyc = 0; wren_cnt = 0; low_cnt = 0; cs_cnt = 0;
        skew = 0; lat = 0; stable_bad = 0; got_data = '0;
        while (adc_convst == 1'b0 && wait_cyc < 100) begin
            @(negedge wrclk); wait_cyc++;
        end
        while (adc_convst == 1'b1 && wait_cyc < 100) begin
            @(negedge wrclk); wait_cyc++;
        end
        if (adc_convst != 1'b0) begin
            chk("convst_seen", 0, 1);
            return;
        end
        found = 1;
        fifo_full = full;
        adc_data  = data;
        adc_busy  = (busy_len > 0);
        low_cnt   = 1;
        prev_wd   = wrdata;
        for (int i = 1; i <= DIV - 2; i++) begin
            @(negedge wrclk);
            if (i >= busy_len) adc_busy = 1'b0;
            if (!adc_convst) low_cnt++;
            if (!adc_cs_n) cs_cnt++;
            if (adc_cs_n != adc_rd_n) skew++;
            if (wren) begin
                wren_cnt++;
                got_data = wrdata;
                lat = i;
                if (wrdata != prev_wd) stable_bad++;
            end
            prev_wd = wrdata;
        end
    endtask

    task automatic do_clr();
        @(negedge wrclk); clr = 1'b1;
        @(negedge wrclk); clr = 1'b0;
        exp_drops = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, cs_fell, wr_seen, tot_wren, d0, cf;
        logic        full;
        logic [15:0] data;

        tbl[0] = '{5, 1'b0, 16'h1234, 1};
        tbl[1] = '{5, 1'b0, 16'h1235, 1};
        tbl[2] = '{5, 1'b1, 16'hAAAA, 0};
        tbl[3] = '{5, 1'b1, 16'hAAAB, 0};
        tbl[4] = '{5, 1'b1, 16'hAAAC, 0};
        tbl[5] = '{3, 1'b0, 16'h0F0F, 1};

        // Reset state
        repeat (3) @(negedge wrclk);
        chk("rst_convst", adc_convst, 1);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_rd_n", adc_rd_n, 1);
        chk("rst_wren", wren, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        @(negedge wrclk);
        en = 1'b1;

        // Table-driven periods: steady sampling then three full-FIFO drops
        for (int i = 0; i < 6; i++) begin
            run_period(tbl[i].busy_len, tbl[i].full, tbl[i].data);
            if (tbl[i].full) exp_drops++;
            chk("tbl_wren", wren_cnt, tbl[i].exp_wren);
            if (tbl[i].exp_wren == 1) begin
                chk("tbl_data", got_data, tbl[i].data);
                chk("tbl_lat_min", (lat >= CP + 6) ? 1 : 0, 1);
                chk("tbl_wrdata_stable", stable_bad, 0);
            end
            chk("tbl_convst_low", low_cnt, CP);
            chk("tbl_cs_cycles", cs_cnt, 2);
            chk("tbl_cs_rd_skew", skew, 0);
            chk("tbl_drop", drop_cnt, sat(exp_drops));
            chk("tbl_ovf", ovf, (exp_drops > 0) ? 1 : 0);
            if (i > 0) chk("tbl_period", (DIV - 2) + wait_cyc, DIV);
        end
        do_clr();
        chk("clr_ovf", ovf, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_wren", wren, 0);

        // Randomized periods against the outcome model
        for (int i = 0; i < 40; i++) begin
            full = ($urandom_range(0, 3) == 0);
            data = 16'($urandom);
            run_period(int'($urandom_range(0, 10)), full, data);
            if (full) exp_drops++;
            chk("rnd_wren", wren_cnt, full ? 0 : 1);
            if (!full) chk("rnd_data", got_data, data);
            chk("rnd_drop", drop_cnt, sat(exp_drops));
            chk("rnd_ovf", ovf, (exp_drops > 0) ? 1 : 0);
        end

        // Drop counter saturation
        do_clr();
        tot_wren = 0;
        for (int i = 0; i < 300; i++) begin
            run_period(2, 1'b1, 16'(i));
            if (found == 1) exp_drops++;
            tot_wren += wren_cnt;
        end
        chk("sat_drop", drop_cnt, 255);
        chk("sat_model", sat(exp_drops), 255);
        chk("sat_wren", tot_wren, 0);
        chk("sat_ovf", ovf, 1);

        // BUSY stuck high: timeout after BUSY_TO cycles in WAIT, then retry
        do_clr();
        fifo_full = 1'b0;
        n = 0;
        while (adc_convst == 1'b0 && n < 100) begin @(negedge wrclk); n++; end
        while (adc_convst == 1'b1 && n < 100) begin @(negedge wrclk); n++; end
        adc_busy = 1'b1;
        n = 0;
        while (adc_convst == 1'b0 && n < 100) begin @(negedge wrclk); n++; end
        n = 0; cs_fell = 0; wr_seen = 0;
        while (!tmo && n < 200) begin
            @(negedge wrclk); n++;
            if (!adc_cs_n) cs_fell = 1;
            if (wren) wr_seen = 1;
        end
        chk("tmo_latency", n, BTO);
        chk("tmo_no_cs", cs_fell, 0);
        chk("tmo_no_wren", wr_seen, 0);
        adc_busy = 1'b0;
        run_period(5, 1'b0, 16'h5A5A);
        chk("retry_wren", wren_cnt, 1);
        chk("retry_data", got_data, 16'h5A5A);
        chk("tmo_sticky", tmo, 1);

        // Asynchronous reset during READ
        n = 0;
        while (adc_cs_n && n < 100) begin @(negedge wrclk); n++; end
        chk("reached_read", adc_cs_n, 0);
        reset = 1'b0;
        #1;
        chk("rmid_cs_n", adc_cs_n, 1);
        chk("rmid_rd_n", adc_rd_n, 1);
        chk("rmid_wren", wren, 0);
        chk("rmid_convst", adc_convst, 1);
        chk("rmid_wrdata", wrdata, 0);
        chk("rmid_tmo", tmo, 0);
        repeat (2) @(negedge wrclk);
        chk("rmid_wren_hold", wren, 0);
        reset = 1'b1;
        exp_drops = 0;
        run_period(4, 1'b0, 16'h7777);
        chk("post_rst_wren", wren_cnt, 1);
        chk("post_rst_lat", (lat >= CP + 6) ? 1 : 0, 1);
        chk("post_rst_data", got_data, 16'h7777);

        // Almost-full behaviour
        fifo_afull = 1'b1;
`ifdef ADC_WR_AFULL_THROTTLE_EN
        d0 = drop_cnt;
        cf = 0;
        repeat (3 * DIV) begin
            @(negedge wrclk);
            if (!adc_convst) cf++;
        end
        chk("thr_no_convst", cf, 0);
        chk("thr_drops", drop_cnt - d0, 3);
        chk("thr_ovf", ovf, 1);
`else
        d0 = drop_cnt;
        cf = 0;
        run_period(3, 1'b0, 16'hBEEF);
        chk("afull_ignored_wren", wren_cnt, 1);
        chk("afull_ignored_data", got_data, 16'hBEEF);
        chk("afull_no_drop", drop_cnt, d0 + cf);
`endif
        fifo_afull = 1'b0;

        // Sampling disabled: no conversions
        en = 1'b0;
        cf = 0;
        repeat (DIV) @(negedge wrclk);
        repeat (3 * DIV) begin
            @(negedge wrclk);
            if (!adc_convst || wren) cf++;
        end
        chk("en_off_idle", cf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_writer.md
# adc_sample_writer

Write-side controller for the 256x16 ADC sampling FIFO. Paces conversions of an external parallel 16-bit ADC at a programmable period, runs the CONVST / BUSY / CS# / RD# handshake, and pushes each sample into the FIFO write port. It honours the FIFO full flag, accounts for every dropped sample, and flags ADC busy timeouts. It sits between the ADC pins and the FIFO's `wrdata`/`wren`/`wrclk` side.

## Interface
- `DIV`, 100: sample period in `wrclk` cycles; legal range 16..65535.
- `CONV_PULSE`, 2: CONVST low width in cycles; legal range 1..15.
- `BUSY_TO`, 200: maximum cycles spent waiting for BUSY to fall before a timeout; legal range 4..255.
- `wrclk` in 1: single clock; the FIFO write clock.
- `reset` in 1: asynchronous, active-low.
- `en` in 1: sampling enable, level-sensitive.
- `adc_busy` in 1: ADC BUSY, asynchronous to `wrclk`.
- `adc_data` in 16: ADC parallel data bus.
- `adc_convst` out 1: conversion start, active-low pulse.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_rd_n` out 1: ADC read strobe, active-low.
- `fifo_full` in 1: FIFO FULL flag.
- `fifo_afull` in 1: FIFO AFULL flag.
- `wrdata` out 16: data to the FIFO.
- `wren` out 1: FIFO write enable, one-cycle pulse.
- `ovf` out 1: sticky flag, set when a sample is dropped.
- `tmo` out 1: sticky flag, set on a BUSY timeout.
- `drop_cnt` out 8: count of dropped samples; saturates at 255.
- `clr` in 1: synchronous clear of `ovf`, `tmo` and `drop_cnt`.

## Operation
- **Reset values:** `adc_convst`=1, `adc_cs_n`=1, `adc_rd_n`=1, `wren`=0, `wrdata`=0, `ovf`=0, `tmo`=0, `drop_cnt`=0. The state machine resets to IDLE and the period counter to 0.
- **BUSY synchronisation:** `adc_busy` passes through a 2-flop synchronizer. Only `busy_s` (the synchronised version) is used internally.
- **Period counter:** runs 0..DIV-1 and wraps while `en`=1. It is held at 0 while `en`=0. A tick is generated when the count is 0 and `en`=1.
- **One-hot state machine:**
  - IDLE: on a tick, go to START. A tick that arrives in any other state is discarded; there is no catch-up.
  - START: drive `adc_convst`=0 for CONV_PULSE cycles, then go to WAIT.
  - WAIT: spend at least 3 cycles in WAIT, covering synchronizer latency plus BUSY rise. After that, `busy_s`=0 moves to READ. If BUSY_TO cycles elapse first, set `tmo`, drop to IDLE and push nothing.
  - READ: 2 cycles with `adc_cs_n`=0 and `adc_rd_n`=0. At the end of the 2nd cycle, register `adc_data` into `wrdata`. Then go to PUSH.
  - PUSH: 1 cycle.
    - If `fifo_full`=0: `wren`=1.
    - If `fifo_full`=1: `wren`=0, set `ovf`, increment `drop_cnt` (saturating).
    - Then go to IDLE.
- **`en` deasserted mid-operation:** the conversion in progress completes through PUSH; no new START follows.
- **`clr`:** when `clr` coincides with a drop, the clear wins.
- **`wrdata`:** holds its last value between pushes.

## Timing
- Tick to `adc_convst` falling edge: 1 cycle.
- Minimum tick-to-`wren` latency is CONV_PULSE + 3 + 2 + 1 cycles; this is 8 with the default parameters.
- At most one `wren` per DIV cycles, and never two consecutive `wren` cycles.
- `adc_cs_n` and `adc_rd_n` are registered outputs and change together.
- `wren` is registered and high for exactly one cycle. `wrdata` is stable on the `wren` cycle and on the cycle before it.
- `fifo_full` is sampled in the PUSH cycle only.
- Asynchronous reset asserted mid-conversion: all outputs return immediately to their reset values, with no partial `wren`.

## Configuration
- `ADC_WR_AFULL_THROTTLE_EN`
- **Defined:** when `fifo_afull`=1 in IDLE at a tick, the tick is skipped (no conversion). `drop_cnt` is incremented and `ovf` is set.
- **Undefined:** `fifo_afull` is ignored, conversions continue, and drops occur only at PUSH when `fifo_full`=1.

## Test plan
- **Steady sampling:** DIV=20, `en`=1, ADC model BUSY high for 5 cycles, data 0x1234 then 0x1235.
  - `wren` pulses every 20 cycles with `wrdata`=0x1234, then 0x1235.
  - `adc_convst` is low for 2 cycles each period.
- **Full FIFO:** `fifo_full`=1 held for 3 periods.
  - `wren` stays 0, `ovf`=1, `drop_cnt`=3.
  - A subsequent `clr` returns all three to 0.
- **BUSY stuck high:** `adc_busy` stuck at 1, BUSY_TO=50.
  - `tmo`=1 at 50 cycles into WAIT, `adc_cs_n` never falls, no `wren`.
  - The next period retries.
- **Drop counter saturation:** 300 ticks with `fifo_full`=1 → `drop_cnt`=255.
- **Reset mid-operation:**
  - `reset` low during READ: `adc_cs_n`/`adc_rd_n`=1 at once, `wren`=0.
  - After release, the first `wren` occurs at least 8 cycles after the first tick.
- **Throttle (macro defined):** `fifo_afull`=1, `fifo_full`=0 → no CONVST pulses, `drop_cnt` increments each period.
  - With the macro undefined, sampling continues normally.
